regfile_wb_sequencer: RTL and testbench
=======================================

// Module: regfile_wb_sequencer
// PURPOSE
//  Write-back controller for the SEQ datapath. It accepts one retiring instruction (icode, cnd, rA, rB, valE, valM) per handshake.
//  It decodes dstE/dstM and sequences the writes onto a single-write-port register file, one write per cycle, E before M.
//  It also arbitrates a low-priority host/loader write port onto the same register-file port.
// PARAMETERS
//  DATA_W  64  width of valE/valM/write data
//  ADDR_W  4   register index width; index 4'hF (RNONE) means "no register"
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high
//  in_valid   in   1       retiring instruction present
//  in_ready   out  1       1 iff FSM in IDLE (combinational from state)
//  in_code    in   4       Y86 icode
//  cnd        in   1       condition result (used by icode 2 only)
//  ra, rb     in   ADDR_W  register specifiers
//  val_e      in   DATA_W  ALU result
//  val_m      in   DATA_W  memory read result
//  host_req   in   1       host write request (level)
//  host_addr  in   ADDR_W  host write register
//  host_data  in   DATA_W  host write data
//  host_gnt   out  1       1-cycle pulse: host write performed this cycle
//  wr_en      out  1       register-file write enable
//  wr_addr    out  ADDR_W  register-file write index
//  wr_data    out  DATA_W  register-file write data
//  retire     out  1       1-cycle pulse on final cycle of an accepted instruction
//  bad_code   out  1       pulses with retire when icode > 4'hB
// BEHAVIOUR
//  Reset: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, host_gnt=0, retire=0, bad_code=0. All outputs except in_ready are registered.
//  Dest decode (cnd ignored except icode 2):
//    2: dstE=rB if cnd, else none.  3, 6: dstE=rB.  5: dstM=rA.
//    8, 9, A: dstE=RSP(4).  B: dstE=RSP, dstM=rA.
//    0, 1, 4, 7: none.  C-F: none, plus bad_code.
//    Any dst equal to RNONE is treated as none.
//  Accept: in_valid && in_ready at edge k latches valE, valM, dstE and dstM.
//  FSM: IDLE -> WR_E if dstE valid; IDLE -> WR_M if only dstM valid; IDLE -> RET if neither.
//       WR_E -> WR_M if dstM valid, else -> IDLE.  WR_M -> IDLE.  RET -> IDLE.
//  Cycle k+1: first write (or RET) visible on the outputs. popq: E at k+1, M at k+2.
//  retire asserts in the last active cycle; bad_code asserts with it.
//  Throughput: at most one instruction per 2 cycles; in_ready is low in WR_E, WR_M and RET.
//  popq with rA==RSP: writes RSP<-valE then RSP<-valM, so valM wins (Y86 semantics). Both writes are still issued.
//  Host: granted only in IDLE with in_valid==0 at the edge. The next cycle has wr_en=1, wr_addr=host_addr, wr_data=host_data and host_gnt=1.
//    The FSM stays IDLE for that cycle, so in_ready stays 1.
//    host_addr==RNONE: host_gnt pulses, wr_en stays 0.
//  Simultaneous in_valid and host_req: the instruction wins, and the host waits until the next free IDLE.
//  Reset mid-sequence (e.g. in WR_E): pending M write is dropped; wr_en and retire are 0 from assertion.
//  Data inputs are not required to stay stable after accept.
// STRUCTURE
//  Package y86_pkg:
//    icode localparams (IHALT..IPOPQ), RSP=4'h4, RNONE=4'hF.
//    State enum {IDLE, WR_E, WR_M, RET}.
//  Sub-module wb_dest_decode: combinational icode/cnd/ra/rb -> dst_e, dst_m, bad.
//  The top holds the FSM, the payload registers and the host arbitration.
// TESTING
//  1. irmovq (3), rb=2, valE=21 -> k+1: wr_en=1, addr=2, data=21, retire=1. k+2: wr_en=0, in_ready=1.
//  2. popq (B), ra=3, valE=81, valM=66 -> k+1: addr=4, data=81. k+2: addr=3, data=66, retire=1.
//     popq with ra=4 -> last write is addr 4, data 66.
//  3. cmovXX (2), rb=5, valE=77:
//       cnd=0 -> no write, retire at k+1 (RET state).
//       cnd=1 -> addr=5, data=77.
//  4. rmmovq (4), then icode E -> each retires with wr_en=0. The icode E case also pulses bad_code.
//  5. host_req addr=7 data=262 in the same cycle as in_valid OPq (6), rb=1, valE=261:
//     OPq write first (addr 1, 261), then host write (addr 7, 262) with host_gnt.
//  6. Reset asserted in the WR_E cycle of a popq -> no M write; outputs zero; then IDLE with in_ready=1.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 icodes, register indices and write-back FSM states
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_E = 2'd1,
        WR_M = 2'd2,
        RET  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_dest_decode.sv
// rtl/wb_dest_decode.sv - icode/cnd/rA/rB to write-back destinations
module wb_dest_decode
    import y86_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic [3:0]        icode_i,
    input  logic              cnd_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [ADDR_W-1:0] rb_i,
    output logic [ADDR_W-1:0] dst_e_o,
    output logic [ADDR_W-1:0] dst_m_o,
    output logic              bad_o
);

    localparam logic [ADDR_W-1:0] NONE = '1;
    localparam logic [ADDR_W-1:0] SP   = ADDR_W'(RSP);

    always_comb begin
        dst_e_o = NONE;
        dst_m_o = NONE;
        bad_o   = 1'b0;
        case (icode_i)
            IRRMOVQ: if (cnd_i) dst_e_o = rb_i;
            IIRMOVQ,
            IOPQ:    dst_e_o = rb_i;
            IMRMOVQ: dst_m_o = ra_i;
            ICALL,
            IRET,
            IPUSHQ:  dst_e_o = SP;
            IPOPQ: begin
                dst_e_o = SP;
                dst_m_o = ra_i;
            end
            IHALT, INOP, IRMMOVQ, IJXX: ;
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// rtl/regfile_wb_sequencer.sv - sequences E/M write-backs and host writes onto one register-file port
module regfile_wb_sequencer
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_code,
    input  logic              cnd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_gnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              retire,
    output logic              bad_code
);

    localparam logic [ADDR_W-1:0] NONE = '1;

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] dst_m_q, dst_m_d;
    logic [DATA_W-1:0] val_m_q, val_m_d;
    logic              wr_en_d, host_gnt_d, retire_d, bad_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    logic [ADDR_W-1:0] dec_e, dec_m;
    logic              dec_bad;

    wb_dest_decode #(.ADDR_W(ADDR_W)) u_decode (
        .icode_i (in_code),
        .cnd_i   (cnd),
        .ra_i    (ra),
        .rb_i    (rb),
        .dst_e_o (dec_e),
        .dst_m_o (dec_m),
        .bad_o   (dec_bad)
    );

    assign in_ready = (state_q == IDLE);

    // Outputs are computed for the state being entered, so the first write lands one cycle after accept.
    always_comb begin
        state_d    = state_q;
        dst_m_d    = dst_m_q;
        val_m_d    = val_m_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        host_gnt_d = 1'b0;
        retire_d   = 1'b0;
        bad_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dst_m_d = dec_m;
                    val_m_d = val_m;
                    if (dec_e != NONE) begin
                        state_d   = WR_E;
                        wr_en_d   = 1'b1;
                        wr_addr_d = dec_e;
                        wr_data_d = val_e;
                        retire_d  = (dec_m == NONE);
                    end else if (dec_m != NONE) begin
                        state_d   = WR_M;
                        wr_en_d   = 1'b1;
                        wr_addr_d = dec_m;
                        wr_data_d = val_m;
                        retire_d  = 1'b1;
                    end else begin
                        state_d  = RET;
                        retire_d = 1'b1;
                        bad_d    = dec_bad;
                    end
                end else if (host_req) begin
                    host_gnt_d = 1'b1;
                    wr_en_d    = (host_addr != NONE);
                    wr_addr_d  = host_addr;
                    wr_data_d  = host_data;
                end
            end
            WR_E: begin
                if (dst_m_q != NONE) begin
                    state_d   = WR_M;
                    wr_en_d   = 1'b1;
                    wr_addr_d = dst_m_q;
                    wr_data_d = val_m_q;
                    retire_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_M:    state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dst_m_q  <= NONE;
            val_m_q  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            host_gnt <= 1'b0;
            retire   <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            state_q  <= state_d;
            dst_m_q  <= dst_m_d;
            val_m_q  <= val_m_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            host_gnt <= host_gnt_d;
            retire   <= retire_d;
            bad_code <= bad_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb/tb_regfile_wb_sequencer.sv - self-checking bench for regfile_wb_sequencer
module tb_regfile_wb_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        cnd;
    logic [3:0]  ra, rb;
    logic [63:0] val_e, val_m;
    logic        host_req;
    logic [3:0]  host_addr;
    logic [63:0] host_data;
    logic        host_gnt;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic        retire;
    logic        bad_code;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;

    regfile_wb_sequencer #(.DATA_W(64), .ADDR_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .cnd       (cnd),
        .ra        (ra),
        .rb        (rb),
        .val_e     (val_e),
        .val_m     (val_m),
        .host_req  (host_req),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_gnt  (host_gnt),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .retire    (retire),
        .bad_code  (bad_code)
    );

    always #5 clock = ~clock;

    // Architectural list of register writes an instruction must produce, in order.
    task automatic expected_writes(input logic [3:0] ic, input logic c, input logic [3:0] a, b,
                                   input logic [63:0] ve, vm, output wr_t q[$], output bit bad);
        logic [3:0] e, m;
        e = 4'hF;
        m = 4'hF;
        case (ic)
            4'h2:             if (c) e = b;
            4'h3, 4'h6:       e = b;
            4'h5:             m = a;
            4'h8, 4'h9, 4'hA: e = 4'h4;
            4'hB: begin e = 4'h4; m = a; end
            default: ;
        endcase
        bad = (ic > 4'hB);
        q = {};
        if (e != 4'hF) q.push_back('{e, ve});
        if (m != 4'hF) q.push_back('{m, vm});
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic run_instr(input string name, input logic [3:0] ic, input logic c,
                             input logic [3:0] a, b, input logic [63:0] ve, vm);
        wr_t q[$];
        bit  bad;
        int  ncyc;
        logic exp_en;
        expected_writes(ic, c, a, b, ve, vm, q, bad);
        ncyc = (q.size() == 0) ? 1 : q.size();
        check({name, "_ready"}, 128'(in_ready), 128'(1'b1));
        in_valid = 1'b1; in_code = ic; cnd = c; ra = a; rb = b; val_e = ve; val_m = vm;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            if (i == 0) begin
                in_valid = 1'b0;
                in_code  = 4'($urandom);
                ra       = 4'($urandom);
                rb       = 4'($urandom);
                val_e    = {$urandom, $urandom};
                val_m    = {$urandom, $urandom};
            end
            exp_en = (q.size() > 0);
            check({name, "_ctl"}, 128'({wr_en, retire, bad_code, host_gnt, in_ready}),
                  128'({exp_en, i == ncyc - 1, bad && (i == ncyc - 1), 1'b0, 1'b0}));
            if (exp_en)
                check({name, "_wr"}, {60'd0, wr_addr, wr_data}, {60'd0, q[i].addr, q[i].data});
        end
        @(negedge clock);
        check({name, "_after"}, 128'({wr_en, retire, in_ready}), 128'(3'b001));
    endtask

    task automatic host_write(input string name, input logic [3:0] a, input logic [63:0] d);
        host_req = 1'b1; host_addr = a; host_data = d;
        @(negedge clock);
        host_req = 1'b0;
        check({name, "_ctl"}, 128'({host_gnt, wr_en, in_ready}), 128'({1'b1, a != 4'hF, 1'b1}));
        if (a != 4'hF) check({name, "_wr"}, {60'd0, wr_addr, wr_data}, {60'd0, a, d});
        @(negedge clock);
        check({name, "_after"}, 128'({host_gnt, wr_en}), 128'(2'b00));
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_code = 0; cnd = 0; ra = 0; rb = 0;
        val_e = 0; val_m = 0; host_req = 1'b0; host_addr = 0; host_data = 0;
        repeat (2) @(negedge clock);
        check("reset_outputs", {55'd0, wr_en, wr_addr, wr_data, host_gnt, retire, bad_code, in_ready},
              {55'd0, 1'b0, 4'd0, 64'd0, 3'b000, 1'b1});
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        run_instr("irmovq", 4'h3, 1'b0, 4'hF, 4'h2, 64'd21, 64'd0);
        run_instr("popq_ra3", 4'hB, 1'b0, 4'h3, 4'hF, 64'd81, 64'd66);
        run_instr("popq_rsp", 4'hB, 1'b0, 4'h4, 4'hF, 64'd81, 64'd66);
        run_instr("cmov_nc", 4'h2, 1'b0, 4'h1, 4'h5, 64'd77, 64'd0);
        run_instr("cmov_c", 4'h2, 1'b1, 4'h1, 4'h5, 64'd77, 64'd0);
        run_instr("rmmovq", 4'h4, 1'b1, 4'h1, 4'h2, 64'd5, 64'd6);
        run_instr("bad_e", 4'hE, 1'b1, 4'h1, 4'h2, 64'd5, 64'd6);
        run_instr("mrmovq", 4'h5, 1'b0, 4'h7, 4'h2, 64'd9, 64'd99);
        run_instr("opq_rnone", 4'h6, 1'b0, 4'h7, 4'hF, 64'd9, 64'd99);
    endtask

    task automatic test_host_collision();
        in_valid = 1'b1; in_code = 4'h6; cnd = 0; ra = 4'hF; rb = 4'h1; val_e = 64'd261;
        host_req = 1'b1; host_addr = 4'h7; host_data = 64'd262;
        @(negedge clock);
        in_valid = 1'b0;
        check("coll_opq", {58'd0, wr_en, retire, host_gnt, wr_addr, wr_data, in_ready},
              {58'd0, 1'b1, 1'b1, 1'b0, 4'd1, 64'd261, 1'b0});
        @(negedge clock);
        check("coll_gap", 128'({wr_en, host_gnt, in_ready}), 128'(3'b001));
        @(negedge clock);
        host_req = 1'b0;
        check("coll_host", {58'd0, wr_en, retire, host_gnt, wr_addr, wr_data, in_ready},
              {58'd0, 1'b1, 1'b0, 1'b1, 4'd7, 64'd262, 1'b1});
        @(negedge clock);
        check("coll_done", 128'({wr_en, host_gnt}), 128'(2'b00));
        host_write("host_rnone", 4'hF, 64'd1234);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_code = 4'hB; ra = 4'h3; val_e = 64'd81; val_m = 64'd66;
        @(negedge clock);
        in_valid = 1'b0;
        check("rst_mid_e", {59'd0, wr_en, wr_addr, wr_data}, {59'd0, 1'b1, 4'd4, 64'd81});
        reset = 1'b1;
        #1;
        check("rst_mid_zero", {57'd0, wr_en, retire, host_gnt, bad_code, wr_addr, wr_data},
              {57'd0, 4'b0000, 4'd0, 64'd0});
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_idle", 128'({wr_en, retire, in_ready}), 128'(3'b001));
        @(negedge clock);
        check("rst_mid_no_m", 128'({wr_en, retire}), 128'(2'b00));
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                host_write("rand_host", 4'($urandom), {$urandom, $urandom});
            else
                run_instr("rand_instr", 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                          {$urandom, $urandom}, {$urandom, $urandom});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_host_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
